// File: rtl/mod6_counter_if.sv
// Pin bundle for the mod6_counter user block: harness-driven inputs and
// the three output buses of the standard TT pin set.
interface mod6_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Harness / testbench side
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // User design side
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/mod6_counter.sv
// Modulo-6 up/down counter with clear, clamped parallel load, seven-segment
// decode, a one-cycle wrap pulse and a 4-bit wrap tally. All outputs come
// straight from registers (or a decoder fed only by registers), so there is
// no combinational path from ui_in to any pin.
module mod6_counter (
  input  logic clk,
  input  logic rst_n,          // active-high asynchronous reset despite the name
  mod6_counter_if.slave bus
);

  // Input field decode
  logic       cnt_en;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic       clear;

  assign cnt_en   = bus.ui_in[0];
  assign dir      = bus.ui_in[1];
  assign load     = bus.ui_in[2];
  assign load_val = bus.ui_in[5:3];
  assign clear    = bus.ui_in[6];

  // ui_in[7] and all of uio_in are intentionally ignored
  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ui_in[7], bus.uio_in};

  // State
  logic [2:0] count_reg, count_next;
  logic       wrap_reg,  wrap_next;
  logic [3:0] tally_reg, tally_next;
  logic       dir_reg;

  // Next-state selection: clear > load > count up/down > hold
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    tally_next = tally_reg;

    if (clear) begin
      count_next = 3'd0;
    end else if (load) begin
      // Out-of-range load values fold back into 0..5 (6 -> 0, 7 -> 1)
      if (load_val <= 3'd5) begin
        count_next = load_val;
      end else if (load_val == 3'd6) begin
        count_next = 3'd0;
      end else begin
        count_next = 3'd1;
      end
    end else if (cnt_en && !dir) begin
      if (count_reg == 3'd5) begin
        count_next = 3'd0;
        wrap_next  = 1'b1;
        tally_next = tally_reg + 4'd1;
      end else if (count_reg > 3'd5) begin
        // Illegal state recovery: step straight to 0, no wrap reported
        count_next = 3'd0;
      end else begin
        count_next = count_reg + 3'd1;
      end
    end else if (cnt_en && dir) begin
      if (count_reg == 3'd0) begin
        count_next = 3'd5;
        wrap_next  = 1'b1;
        tally_next = tally_reg + 4'd1;
      end else if (count_reg > 3'd5) begin
        count_next = 3'd0;
      end else begin
        count_next = count_reg - 3'd1;
      end
    end
  end

  // State registers; ena low freezes everything, including a pending wrap pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_reg <= 3'd0;
      wrap_reg  <= 1'b0;
      tally_reg <= 4'd0;
      dir_reg   <= 1'b0;
    end else if (bus.ena) begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      tally_reg <= tally_next;
      dir_reg   <= dir;
    end
  end

  // Seven-segment decode of the registered count (bit0 = a); blank when illegal
  logic [6:0] seg;
  always_comb begin
    seg = 7'h00;
    case (count_reg)
      3'd0:    seg = 7'h3F;
      3'd1:    seg = 7'h06;
      3'd2:    seg = 7'h5B;
      3'd3:    seg = 7'h4F;
      3'd4:    seg = 7'h66;
      3'd5:    seg = 7'h6D;
      default: seg = 7'h00;
    endcase
  end

  assign bus.uo_out  = {wrap_reg, seg};
  assign bus.uio_out = {tally_reg, dir_reg, count_reg};

  // Every bidirectional pin is an output
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_oe
      assign bus.uio_oe[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_mod6_counter.sv
// Directed bench for mod6_counter: walks through reset, counting, down wrap,
// load clamping, clear priority, ena gating, tally rollover and async reset.
module tb_mod6_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mod6_counter_if bus ();

  mod6_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Apply one input vector for one clock and check both output buses
  task automatic step(input string tag, input logic [7:0] ui, input logic [7:0] exp_uo,
                      input logic [7:0] exp_uio);
    bus.ui_in = ui;
    tick();
    check({tag, ".uo"}, bus.uo_out, exp_uo);
    check({tag, ".uio"}, bus.uio_out, exp_uio);
    $display("step %-12s ui=%02h uo=%02h uio=%02h", tag, ui, bus.uo_out, bus.uio_out);
  endtask

  logic [7:0] up_uo  [7];
  logic [7:0] up_uio [7];
  logic [3:0] exp_tally;

  initial begin
    total = 0;
    bad   = 0;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'hA5;
    rst_n      = 1'b1;

    // Reset held for two cycles
    tick();
    tick();
    check("rst.uo", bus.uo_out, 8'h3F);
    check("rst.uio", bus.uio_out, 8'h00);
    check("rst.oe", bus.uio_oe, 8'hFF);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.ena = 1'b1;

    // Up count through a wrap: 1,2,3,4,5,0(pulse, tally=1),1
    up_uo  = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'hBF, 8'h06};
    up_uio = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11};
    for (int i = 0; i < 7; i++) begin
      step($sformatf("up%0d", i), 8'h01, up_uo[i], up_uio[i]);
    end

    // Clear to 0, then down wrap 0->5 with pulse, tally=2, dir echo
    step("clr0", 8'h40, 8'h3F, 8'h10);
    step("down", 8'h03, 8'hED, 8'h2D);
    step("hold", 8'h00, 8'h6D, 8'h25);

    // Loads, including clamp of 7 and 6, and load beating cnt_en
    step("ld3", 8'h1C, 8'h4F, 8'h23);
    step("ld7en", 8'h3D, 8'h06, 8'h21);
    step("ld6", 8'h34, 8'h3F, 8'h20);
    step("ld5en", 8'h2D, 8'h6D, 8'h25);
    step("ld0en", 8'h05, 8'h3F, 8'h20);

    // Clear beats load and count; tally untouched
    step("ld4", 8'h24, 8'h66, 8'h24);
    step("clrpri", 8'h45, 8'h3F, 8'h20);

    // Up wrap then freeze with ena low; pulse must stretch
    step("ld5", 8'h2C, 8'h6D, 8'h25);
    step("wrap", 8'h01, 8'hBF, 8'h30);
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("gate%0d", i), 8'h43, 8'hBF, 8'h30);
    end
    bus.ena = 1'b1;
    step("ungate", 8'h00, 8'h3F, 8'h30);

    // Repeated down wraps drive the tally 3 -> 15 -> 0
    exp_tally = 4'd3;
    for (int i = 0; i < 13; i++) begin
      exp_tally = exp_tally + 4'd1;
      step($sformatf("tw%0d", i), 8'h03, 8'hED, {exp_tally, 4'hD});
      step($sformatf("tl%0d", i), 8'h06, 8'h3F, {exp_tally, 4'h8});
    end
    step("tally0", 8'h04, 8'h3F, 8'h00);

    // Async reset between edges at count=3
    step("ld3b", 8'h1C, 8'h4F, 8'h03);
    bus.ui_in = 8'h01;
    #2;
    rst_n = 1'b1;
    #1;
    check("arst.uo", bus.uo_out, 8'h3F);
    check("arst.uio", bus.uio_out, 8'h00);
    check("arst.oe", bus.uio_oe, 8'hFF);
    $display("step %-12s uo=%02h uio=%02h", "async_rst", bus.uo_out, bus.uio_out);
    step("inrst", 8'h01, 8'h3F, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    step("postrst", 8'h01, 8'h06, 8'h01);
    check("end.oe", bus.uio_oe, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
